// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: raster-order read master for the framebuffer RAM.
// Walks the RAM with a running address counter, presents VGA-timed pixels
// and active-low syncs one pixel tick behind the counters, and pulses
// frame_start_o for one clock when the scan wraps to (0,0).
// Optional build macro FRAME_BORDER_EN: forces the outermost visible
// pixels of the frame to all-ones without changing addressing or timing.
module framebuffer_scanout #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  pixel_tick_i,
  output logic [ADDR_WIDTH-1:0] rd_address_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] pixel_o,
  output logic                  video_en_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Address of the last visible pixel; the running address wraps after it.
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

`ifdef FRAME_BORDER_EN
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
`endif

  logic [HW-1:0]         hcount_q, hcount_d;
  logic [VW-1:0]         vcount_q, vcount_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] pixel_q, pixel_d;
  logic                  video_en_q, video_en_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  frame_start_q, frame_start_d;

  logic                  active;
  logic                  h_sync_on;
  logic                  v_sync_on;
  logic                  at_frame_end;
  logic [DATA_WIDTH-1:0] src_pixel;

  // Decode the current scan position: visibility, sync windows, pixel source.
  always_comb begin
    active       = (hcount_q < H_ACT_C) && (vcount_q < V_ACT_C);
    h_sync_on    = (hcount_q >= H_SYNC_S) && (hcount_q < H_SYNC_E);
    v_sync_on    = (vcount_q >= V_SYNC_S) && (vcount_q < V_SYNC_E);
    at_frame_end = (hcount_q == H_LAST_C) && (vcount_q == V_LAST_C);
`ifdef FRAME_BORDER_EN
    if ((hcount_q == '0) || (hcount_q == H_ACT_LAST) ||
        (vcount_q == '0) || (vcount_q == V_ACT_LAST)) begin
      src_pixel = '1;
    end else begin
      src_pixel = rd_data_i;
    end
`else
    src_pixel = rd_data_i;
`endif
  end

  // On each pixel tick advance the counters and address, and capture the
  // outputs for the position being left; between ticks everything holds.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    addr_d        = addr_q;
    pixel_d       = pixel_q;
    video_en_d    = video_en_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
    if (pixel_tick_i) begin
      if (hcount_q == H_LAST_C) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST_C) ? '0 : vcount_q + VW'(1);
      end else begin
        hcount_d = hcount_q + HW'(1);
      end
      // The address only moves across visible pixels, so it lands on the
      // next line start during blanking and equals v*H_ACTIVE+h when visible.
      if (active) begin
        addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_WIDTH'(1);
      end
      // rd_data_i is valid here: the address has been stable since the
      // previous tick, which is at least two clocks back.
      video_en_d    = active;
      pixel_d       = active ? src_pixel : '0;
      hsync_d       = ~h_sync_on;
      vsync_d       = ~v_sync_on;
      frame_start_d = at_frame_end;
    end
  end

  // State and output registers with asynchronous reset to the idle/blank state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      addr_q        <= '0;
      pixel_q       <= '0;
      video_en_q    <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      addr_q        <= addr_d;
      pixel_q       <= pixel_d;
      video_en_q    <= video_en_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rd_address_o  = addr_q;
  assign pixel_o       = pixel_q;
  assign video_en_o    = video_en_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: a full-size 640x480 instance (A) checks the
// address sweep, pixel path, hsync window, hold and reset behaviour; a tiny
// 8x4 instance (B) covers vsync, address wrap and frame_start over two frames.
module tb_framebuffer_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default timing
  logic        reset_a, tick_a;
  logic [18:0] addr_a;
  logic [7:0]  data_a, pix_a;
  logic        ven_a, hs_a, vs_a, fs_a;

  // Instance B: 8x4 visible, H 8+2+3+3=16, V 4+1+2+1=8, 128 ticks per frame
  logic        reset_b, tick_b;
  logic [4:0]  addr_b;
  logic [7:0]  data_b, pix_b;
  logic        ven_b, hs_b, vs_b, fs_b;

  framebuffer_scanout dut_a (
    .clk_i(clk), .reset_i(reset_a), .pixel_tick_i(tick_a),
    .rd_address_o(addr_a), .rd_data_i(data_a), .pixel_o(pix_a),
    .video_en_o(ven_a), .hsync_o(hs_a), .vsync_o(vs_a), .frame_start_o(fs_a)
  );

  framebuffer_scanout #(
    .ADDR_WIDTH(5), .DATA_WIDTH(8),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk_i(clk), .reset_i(reset_b), .pixel_tick_i(tick_b),
    .rd_address_o(addr_b), .rd_data_i(data_b), .pixel_o(pix_b),
    .video_en_o(ven_b), .hsync_o(hs_b), .vsync_o(vs_b), .frame_start_o(fs_b)
  );

  // RAM models: data = address low bits, one clock read latency
  always @(posedge clk) begin
    data_a <= addr_a[7:0];
    data_b <= {3'b000, addr_b};
  end

  typedef struct {
    int          idx;
    logic        ven;
    logic [7:0]  pix;
    logic        hs;
    logic        vs;
    logic [18:0] addr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_now_a[$];
  event now_ev_a;

  int checks = 0;
  int failures = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  int fs_pulses_b = 0;

  function automatic logic [7:0] exp_pix(int h, int v, int hact, int vact, int data);
`ifdef FRAME_BORDER_EN
    if (h == 0 || h == hact - 1 || v == 0 || v == vact - 1) return 8'hFF;
`endif
    return data[7:0];
  endfunction

  function automatic exp_t mk(int idx, logic ven, logic [7:0] pix, logic hs, logic vs,
                              logic [18:0] addr);
    exp_t e;
    e.idx = idx; e.ven = ven; e.pix = pix; e.hs = hs; e.vs = vs; e.addr = addr;
    return e;
  endfunction

  task automatic chk(input string nm, input exp_t e, input logic ven, input logic [7:0] pix,
                     input logic hs, input logic vs, input logic [18:0] addr);
    checks++;
    if (ven !== e.ven || pix !== e.pix || hs !== e.hs || vs !== e.vs || addr !== e.addr) begin
      failures++;
      $display("FAIL %s n=%0d got ven=%0b pix=%0d hs=%0b vs=%0b addr=%0d required ven=%0b pix=%0d hs=%0b vs=%0b addr=%0d",
               nm, e.idx, ven, pix, hs, vs, addr, e.ven, e.pix, e.hs, e.vs, e.addr);
    end else begin
      $display("ok %s n=%0d ven=%0b pix=%0d hs=%0b vs=%0b addr=%0d",
               nm, e.idx, ven, pix, hs, vs, addr);
    end
  endtask

  // ---------------- Monitor A ----------------
  logic tick_a_seen = 1'b0;
  logic tick_b_seen = 1'b0;
  always @(posedge clk) begin
    tick_a_seen <= tick_a && !reset_a;
    tick_b_seen <= tick_b && !reset_b;
  end

  logic        snap_ven_a, snap_hs_a, snap_vs_a;
  logic [7:0]  snap_pix_a;
  logic [18:0] snap_addr_a;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (reset_a) begin
      cnt_a = 0;
    end else if (tick_a_seen) begin
      cnt_a++;
      if (q_a.size() > 0 && q_a[0].idx == cnt_a) begin
        e = q_a.pop_front();
        chk("tick_a", e, ven_a, pix_a, hs_a, vs_a, addr_a);
      end
    end else begin
      checks++;
      if (ven_a !== snap_ven_a || pix_a !== snap_pix_a || hs_a !== snap_hs_a ||
          vs_a !== snap_vs_a || addr_a !== snap_addr_a) begin
        failures++;
        $display("FAIL hold_a t=%0t got ven=%0b pix=%0d hs=%0b vs=%0b addr=%0d required ven=%0b pix=%0d hs=%0b vs=%0b addr=%0d",
                 $time, ven_a, pix_a, hs_a, vs_a, addr_a,
                 snap_ven_a, snap_pix_a, snap_hs_a, snap_vs_a, snap_addr_a);
      end
    end
    snap_ven_a = ven_a; snap_pix_a = pix_a; snap_hs_a = hs_a;
    snap_vs_a = vs_a; snap_addr_a = addr_a;
    // A never completes a frame in this run
    checks++;
    if (fs_a !== 1'b0) begin
      failures++;
      $display("FAIL frame_start_a t=%0t got %0b required 0", $time, fs_a);
    end
  end

  // Immediate-state checks for A (reset assertion / release)
  always @(now_ev_a) begin : mon_now_a
    exp_t e;
    while (q_now_a.size() > 0) begin
      e = q_now_a.pop_front();
      chk("reset_a", e, ven_a, pix_a, hs_a, vs_a, addr_a);
      checks++;
      if (fs_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_fs_a got %0b required 0", fs_a);
      end
    end
  end

  // ---------------- Monitor B ----------------
  always @(negedge clk) begin : mon_b
    exp_t e;
    logic exp_fs;
    exp_fs = 1'b0;
    if (reset_b) begin
      cnt_b = 0;
    end else if (tick_b_seen) begin
      cnt_b++;
      exp_fs = (cnt_b % 128) == 0;
      if (q_b.size() > 0 && q_b[0].idx == cnt_b) begin
        e = q_b.pop_front();
        chk("tick_b", e, ven_b, pix_b, hs_b, vs_b, {14'd0, addr_b});
      end
    end
    if (fs_b === 1'b1) fs_pulses_b++;
    checks++;
    if (fs_b !== exp_fs) begin
      failures++;
      $display("FAIL frame_start_b t=%0t n=%0d got %0b required %0b", $time, cnt_b, fs_b, exp_fs);
    end
  end

  // ---------------- Stimulus ----------------
  task automatic pulse_a();
    @(negedge clk); #1 tick_a = 1'b1;
    @(negedge clk); #1 tick_a = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_b();
    @(negedge clk); #1 tick_b = 1'b1;
    @(negedge clk); #1 tick_b = 1'b0;
  endtask

  task automatic run_a();
    int h;
    reset_a = 1'b1;
    tick_a  = 1'b0;
    // Line 0: address k+1 after leaving pixel k, holds 640 in blanking,
    // hsync low for h = 656..751
    for (int n = 1; n <= 800; n++) begin
      h = n - 1;
      q_a.push_back(mk(n, h < 640, (h < 640) ? exp_pix(h, 0, 640, 480, h & 255) : 8'd0,
                       !(h >= 656 && h < 752), 1'b1, (h < 640) ? 19'(h + 1) : 19'd640));
    end
    // Line 1 directed points
    q_a.push_back(mk(801,  1'b1, exp_pix(0, 1, 640, 480, 128),   1'b1, 1'b1, 19'd641));
    q_a.push_back(mk(1439, 1'b1, exp_pix(638, 1, 640, 480, 254), 1'b1, 1'b1, 19'd1279));
    q_a.push_back(mk(1440, 1'b1, 8'd255,                         1'b1, 1'b1, 19'd1280));
    repeat (3) @(negedge clk);
    #1 reset_a = 1'b0;
    #1 q_now_a.push_back(mk(0, 1'b0, 8'd0, 1'b1, 1'b1, 19'd0));
    -> now_ev_a;
    repeat (1440) pulse_a();
    // Tick held low: monitor verifies nothing moves
    repeat (50) @(negedge clk);
    repeat (300) pulse_a();
    // Mid-line asynchronous reset, checked between clock edges
    @(negedge clk); #2 reset_a = 1'b1;
    #1 q_now_a.push_back(mk(0, 1'b0, 8'd0, 1'b1, 1'b1, 19'd0));
    -> now_ev_a;
    repeat (3) @(negedge clk);
    #1 reset_a = 1'b0;
    #1 q_now_a.push_back(mk(0, 1'b0, 8'd0, 1'b1, 1'b1, 19'd0));
    -> now_ev_a;
    for (int n = 1; n <= 3; n++) begin
      q_a.push_back(mk(n, 1'b1, exp_pix(n - 1, 0, 640, 480, n - 1), 1'b1, 1'b1, 19'(n)));
    end
    repeat (3) pulse_a();
    repeat (4) @(negedge clk);
  endtask

  task automatic run_b();
    int p, h, v, a;
    logic act;
    reset_b = 1'b1;
    tick_b  = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      p = (n - 1) % 128;
      h = p % 16;
      v = p / 16;
      act = (h < 8) && (v < 4);
      a = (v < 4) ? ((v * 8 + ((h < 8) ? h + 1 : 8)) % 32) : 0;
      q_b.push_back(mk(n, act, act ? exp_pix(h, v, 8, 4, v * 8 + h) : 8'd0,
                       !(h >= 10 && h < 13), !(v >= 5 && v < 7), 19'(a)));
    end
    repeat (3) @(negedge clk);
    #1 reset_b = 1'b0;
    repeat (256) pulse_b();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    @(negedge clk);
    checks++;
    if (fs_pulses_b != 2) begin
      failures++;
      $display("FAIL frame_pulses_b got %0d required 2", fs_pulses_b);
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got a=%0d b=%0d required a=0 b=0", q_a.size(), q_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
